// File: rtl/vae_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vae_stage_sequencer_if
// Purpose  : Handshake, stage-control and debug signals of the VAE encoder
//            stage sequencer, grouped for connection to its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface vae_stage_sequencer_if #(
    parameter int CNT_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       enc_start;
    logic [3:0]       enc_done;
    logic             lambda_start;
    logic             lambda_done;
    logic             act_start;
    logic             act_done;
    logic             act_mode;
    logic [1:0]       act_sel;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             timeout_err;
    logic             clr_err;
    logic [3:0]       stage_id;
    logic [CNT_W-1:0] cycle_cnt;

    // Sequencer side
    modport master (
        input  in_valid, enc_done, lambda_done, act_done, out_ready, clr_err,
        output in_ready, enc_start, lambda_start, act_start, act_mode, act_sel,
               out_valid, busy, timeout_err, stage_id, cycle_cnt
    );

    // Environment side (sample source, datapath units, result sink)
    modport slave (
        output in_valid, enc_done, lambda_done, act_done, out_ready, clr_err,
        input  in_ready, enc_start, lambda_start, act_start, act_mode, act_sel,
               out_valid, busy, timeout_err, stage_id, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vae_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vae_stage_sequencer
// Purpose  : Done-driven sequencer for the encoder datapath
//            ENC1, softplus, ENC2, softplus, lambda, ENC3, softplus, ENC4,
//            sigmoid. Issues one-cycle start pulses, owns the shared
//            activation unit configuration and guards every stage with a
//            watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module vae_stage_sequencer #(
    parameter int OFFSET     = 2,
    parameter int TIMEOUT_CC = 64,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    vae_stage_sequencer_if.master bus
);

    localparam logic [3:0]       LAST_STAGE  = 4'd8;
    localparam logic [3:0]       NO_STAGE_ID = 4'd15;
    localparam logic [3:0]       SETTLE_LOAD = 4'(OFFSET);
    localparam logic [7:0]       WD_LAST     = 8'(TIMEOUT_CC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t           state;
    logic [3:0]       stage;
    logic [3:0]       settle_cnt;
    logic [7:0]       wd_cnt;
    logic [3:0]       enc_start;
    logic             lambda_start;
    logic             act_start;
    logic             act_mode;
    logic [1:0]       act_sel;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic             timeout_err;
    logic [3:0]       stage_id;
    logic [CNT_W-1:0] cycle_cnt;

    // Decode of the stage about to be issued; vector is {act, lambda, enc[3:0]}
    logic [3:0]       issue_k;
    logic [5:0]       issue_vec;
    logic             issue_mode;
    logic [1:0]       issue_sel;
    logic             stage_done;

    // Stage table: which unit the next stage starts and how the activation
    // unit is configured when that unit is the shared activation.
    always_comb begin
        issue_k    = (state == S_SETTLE) ? 4'd0 : stage + 4'd1;
        issue_vec  = 6'b000000;
        issue_mode = 1'b0;
        issue_sel  = 2'd0;
        case (issue_k)
            4'd0: issue_vec = 6'b000001;
            4'd1: begin issue_vec = 6'b100000; issue_sel = 2'd0; end
            4'd2: issue_vec = 6'b000010;
            4'd3: begin issue_vec = 6'b100000; issue_sel = 2'd1; end
            4'd4: issue_vec = 6'b010000;
            4'd5: issue_vec = 6'b000100;
            4'd6: begin issue_vec = 6'b100000; issue_sel = 2'd2; end
            4'd7: issue_vec = 6'b001000;
            4'd8: begin issue_vec = 6'b100000; issue_sel = 2'd3; issue_mode = 1'b1; end
            default: issue_vec = 6'b000000;
        endcase
    end

    // Only the current stage's own done is looked at; everything else is stray.
    always_comb begin
        stage_done = 1'b0;
        case (stage)
            4'd0:    stage_done = bus.enc_done[0];
            4'd2:    stage_done = bus.enc_done[1];
            4'd5:    stage_done = bus.enc_done[2];
            4'd7:    stage_done = bus.enc_done[3];
            4'd4:    stage_done = bus.lambda_done;
            4'd1, 4'd3, 4'd6, 4'd8:
                     stage_done = bus.act_done;
            default: stage_done = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered; start pulses default low so
    // they last exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            stage        <= 4'd0;
            settle_cnt   <= 4'd0;
            wd_cnt       <= 8'd0;
            enc_start    <= 4'd0;
            lambda_start <= 1'b0;
            act_start    <= 1'b0;
            act_mode     <= 1'b0;
            act_sel      <= 2'd0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            stage_id     <= NO_STAGE_ID;
            cycle_cnt    <= '0;
        end else begin
            enc_start    <= 4'd0;
            lambda_start <= 1'b0;
            act_start    <= 1'b0;

            if (state != S_IDLE && state != S_ERR && cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        cycle_cnt  <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (settle_cnt <= 4'd1) begin
                        state <= S_ISSUE;
                        stage <= issue_k;
                        stage_id <= issue_k;
                        {act_start, lambda_start, enc_start} <= issue_vec;
                        if (issue_vec[5]) begin
                            act_mode <= issue_mode;
                            act_sel  <= issue_sel;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                S_ISSUE: begin
                    state  <= S_WAIT;
                    wd_cnt <= 8'd0;
                end

                S_WAIT: begin
                    // A done arriving on the last watchdog cycle still counts.
                    if (stage_done) begin
                        if (stage == LAST_STAGE) begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                            stage_id  <= NO_STAGE_ID;
                        end else begin
                            state <= S_ISSUE;
                            stage <= issue_k;
                            stage_id <= issue_k;
                            {act_start, lambda_start, enc_start} <= issue_vec;
                            if (issue_vec[5]) begin
                                act_mode <= issue_mode;
                                act_sel  <= issue_sel;
                            end
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= S_ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (bus.out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_ERR: begin
                    // stage_id keeps the failing stage until the error is cleared
                    if (bus.clr_err) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b0;
                        in_ready    <= 1'b1;
                        stage_id    <= NO_STAGE_ID;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.enc_start    = enc_start;
    assign bus.lambda_start = lambda_start;
    assign bus.act_start    = act_start;
    assign bus.act_mode     = act_mode;
    assign bus.act_sel      = act_sel;
    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.busy         = busy;
    assign bus.timeout_err  = timeout_err;
    assign bus.stage_id     = stage_id;
    assign bus.cycle_cnt    = cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vae_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vae_stage_sequencer
// Purpose  : Directed self-checking bench for vae_stage_sequencer with a
//            latency-programmable model of the datapath units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vae_stage_sequencer;

    localparam int OFFSET     = 2;
    localparam int TIMEOUT_CC = 64;
    localparam int CNT_W      = 7;
    localparam int NEVER      = 1000;

    // Expected start vector per stage, {act, lambda, enc[3:0]}
    localparam logic [5:0] EXP_SV [9] = '{6'h01, 6'h20, 6'h02, 6'h20, 6'h10,
                                          6'h04, 6'h20, 6'h08, 6'h20};

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vae_stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

    vae_stage_sequencer #(
        .OFFSET     (OFFSET),
        .TIMEOUT_CC (TIMEOUT_CC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         lat [9];
    int         ready_delay;
    bit         stray;
    int         start_cyc [9];
    logic [5:0] start_sv [9];
    logic       amode [9];
    logic [1:0] asel [9];
    int         n_starts, ov_cyc, hv_cnt, err_cyc, overlap, c0, c1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_lat(input int v);
        for (int k = 0; k < 9; k++) lat[k] = v;
    endtask

    task automatic clear_done();
        bus.enc_done    = 4'd0;
        bus.lambda_done = 1'b0;
        bus.act_done    = 1'b0;
    endtask

    // Accept one sample (unless c0_given >= 0), then act as the datapath units
    // and the sink until out_ready is driven, an error shows, or stop_at.
    task automatic run(input int c0_given, input int stop_at, input int budget);
        int         due;
        logic [5:0] due_sv;
        int         due_k;
        bit         act_hold;
        bit         finished;
        logic [5:0] sv;
        n_starts = 0; ov_cyc = -1; hv_cnt = 0; err_cyc = -1; overlap = 0;
        due = -1; due_sv = 6'd0; due_k = -1; act_hold = 1'b0; finished = 1'b0;
        for (int k = 0; k < 9; k++) begin
            start_cyc[k] = -1; start_sv[k] = 6'd0; amode[k] = 1'b0; asel[k] = 2'd0;
        end
        if (c0_given < 0) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < 16 && !bus.in_ready; i++) tick();
            c0 = cyc;
            tick();
            bus.in_valid = 1'b0;
        end else begin
            c0 = c0_given;
        end
        for (int i = 0; i < budget && !finished; i++) begin
            sv = {bus.act_start, bus.lambda_start, bus.enc_start};
            if ($countones(sv) > 1) overlap++;
            if (sv != 6'd0 && n_starts < 9) begin
                start_cyc[n_starts] = cyc - c0;
                start_sv[n_starts]  = sv;
                amode[n_starts]     = bus.act_mode;
                asel[n_starts]      = bus.act_sel;
                if (lat[n_starts] < NEVER) begin
                    due = cyc + lat[n_starts]; due_sv = sv; due_k = n_starts;
                end
                n_starts++;
            end
            bus.enc_done    = 4'd0;
            bus.lambda_done = 1'b0;
            bus.act_done    = act_hold;
            if (stray && cyc == c0 + 5) bus.enc_done[3] = 1'b1;
            if (cyc == due) begin
                if (due_sv[5])      bus.act_done    = 1'b1;
                else if (due_sv[4]) bus.lambda_done = 1'b1;
                else                bus.enc_done    = bus.enc_done | due_sv[3:0];
                if (stray && due_k == 1) act_hold = 1'b1;
                if (due_k == 2)          act_hold = 1'b0;
            end
            if (bus.timeout_err) begin
                err_cyc  = cyc - c0;
                finished = 1'b1;
            end else if (cyc - c0 == stop_at) begin
                finished = 1'b1;
            end else if (bus.out_valid) begin
                if (ov_cyc < 0) ov_cyc = cyc - c0;
                hv_cnt++;
                if (cyc - c0 - ov_cyc >= ready_delay) begin
                    bus.out_ready = 1'b1;
                    finished      = 1'b1;
                end
            end
            if (!finished) tick();
        end
        check("run_ended", {31'd0, finished}, 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_err   = 1'b0;
        clear_done();
        ready_delay = 0;
        stray       = 1'b0;
        set_lat(1);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_err",       bus.timeout_err, 0);
        check("rst_stage_id",  bus.stage_id, 15);
        check("rst_cycle_cnt", bus.cycle_cnt, 0);
        check("rst_starts",    {bus.act_start, bus.lambda_start, bus.enc_start}, 0);
        check("rst_act_cfg",   {bus.act_mode, bus.act_sel}, 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // ---- ideal units: done one cycle after each start ----
        run(-1, -1, 200);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("ideal_start_cyc%0d", k), start_cyc[k], 3 + 2 * k);
            check($sformatf("ideal_start_sv%0d", k), start_sv[k], EXP_SV[k]);
        end
        check("ideal_mode1", amode[1], 0); check("ideal_sel1", asel[1], 0);
        check("ideal_mode3", amode[3], 0); check("ideal_sel3", asel[3], 1);
        check("ideal_mode6", amode[6], 0); check("ideal_sel6", asel[6], 2);
        check("ideal_mode8", amode[8], 1); check("ideal_sel8", asel[8], 3);
        check("ideal_out_valid_cyc", ov_cyc, 21);
        check("ideal_overlap", overlap, 0);
        check("ideal_cnt_at_hold", bus.cycle_cnt, 20);
        check("ideal_busy_hold", bus.busy, 1);
        check("ideal_in_ready_hold", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        check("ideal_idle_in_ready", bus.in_ready, 1);
        check("ideal_idle_out_valid", bus.out_valid, 0);
        check("ideal_idle_cnt", bus.cycle_cnt, 21);
        tick();
        check("ideal_idle_cnt_held", bus.cycle_cnt, 21);

        // ---- variable latency, sink stalls out_valid for 5 cycles ----
        set_lat(3); lat[0] = 10; lat[4] = 8; ready_delay = 4;
        run(-1, -1, 300);
        begin
            int exp_var [9] = '{3, 14, 18, 22, 26, 35, 39, 43, 47};
            for (int k = 0; k < 9; k++)
                check($sformatf("var_start_cyc%0d", k), start_cyc[k], exp_var[k]);
        end
        check("var_out_valid_cyc", ov_cyc, 51);
        check("var_hold_cycles", hv_cnt, 5);
        check("var_overlap", overlap, 0);
        tick();
        bus.out_ready = 1'b0;
        clear_done();
        check("var_idle_in_ready", bus.in_ready, 1);
        check("var_idle_out_valid", bus.out_valid, 0);

        // ---- stray dones are ignored ----
        set_lat(1); lat[0] = 5; lat[2] = 3; ready_delay = 0; stray = 1'b1;
        run(-1, -1, 200);
        check("stray_enc1_hold", start_cyc[1], 9);
        check("stray_enc2_start", start_cyc[2], 11);
        check("stray_enc2_sv", start_sv[2], 6'h02);
        check("stray_act2_start", start_cyc[3], 15);
        check("stray_out_valid_cyc", ov_cyc, 27);
        tick();
        bus.out_ready = 1'b0;
        stray = 1'b0;
        clear_done();

        // ---- watchdog expiry on ENC3 ----
        set_lat(1); lat[5] = NEVER;
        run(-1, -1, 200);
        check("wd_err_cyc", err_cyc, 78);
        check("wd_err_flag", bus.timeout_err, 1);
        check("wd_stage_id", bus.stage_id, 5);
        check("wd_busy", bus.busy, 0);
        check("wd_in_ready", bus.in_ready, 0);
        check("wd_starts", {bus.act_start, bus.lambda_start, bus.enc_start}, 0);
        check("wd_n_starts", n_starts, 6);
        clear_done();
        tick();
        check("wd_err_sticky", bus.timeout_err, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("wd_clr_in_ready", bus.in_ready, 1);
        check("wd_clr_err", bus.timeout_err, 0);

        // ---- done on the 64th WAIT cycle still advances ----
        set_lat(1); lat[5] = 64;
        run(-1, -1, 300);
        check("wd_edge_no_err", err_cyc, -1);
        check("wd_edge_act3_start", start_cyc[6], 78);
        check("wd_edge_out_valid_cyc", ov_cyc, 84);
        tick();
        bus.out_ready = 1'b0;
        clear_done();

        // ---- asynchronous reset in the middle of LAMBDA WAIT ----
        set_lat(1); lat[4] = NEVER;
        run(-1, 13, 100);
        check("rstmid_stage_id_before", bus.stage_id, 4);
        check("rstmid_in_ready_before", bus.in_ready, 0);
        #2 reset = 1'b0;
        #1;
        check("rstmid_starts", {bus.act_start, bus.lambda_start, bus.enc_start}, 0);
        check("rstmid_in_ready", bus.in_ready, 1);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_stage_id", bus.stage_id, 15);
        check("rstmid_cycle_cnt", bus.cycle_cnt, 0);
        clear_done();
        @(negedge clk) reset = 1'b1;
        tick();
        set_lat(1);
        run(-1, -1, 200);
        check("rstmid_rerun_lambda", start_cyc[4], 11);
        check("rstmid_rerun_last", start_cyc[8], 19);
        check("rstmid_rerun_out_valid", ov_cyc, 21);

        // ---- back-to-back: out_ready and in_valid held high ----
        // The rerun above leaves out_ready high in its out_valid cycle.
        bus.in_valid = 1'b1;
        c1 = cyc + 1;
        tick();
        check("b2b_in_ready", bus.in_ready, 1);
        check("b2b_out_valid", bus.out_valid, 0);
        tick();
        check("b2b_cnt_restart", bus.cycle_cnt, 0);
        check("b2b_busy", bus.busy, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        run(c1, -1, 200);
        check("b2b_first_start", start_cyc[0], 3);
        check("b2b_out_valid_cyc", ov_cyc, 21);
        tick();
        bus.out_ready = 1'b0;
        clear_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/vae_stage_sequencer.md
Name: vae_stage_sequencer

Overview:
Handshake-driven sequencer for the encoder datapath: ENC1, softplus, ENC2, softplus, lambda, ENC3, softplus, ENC4, sigmoid.
- Each stage is started with a one-cycle pulse and advanced on that unit's done signal, not on a fixed cycle budget.
- Owns the single shared activation unit and configures its mode and source layer for each activation stage.
- Accepts one sample per run via valid/ready, presents completion via valid/ready, and traps hung stages with a per-stage watchdog.

Parameters:
OFFSET, 2, settle cycles between input acceptance and ENC1 start (1..15)
TIMEOUT_CC, 64, max WAIT cycles per stage before error (1..255)
CNT_W, 7, width of run cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  new sample available
in_ready  out  1  sequencer idle, can accept
enc_start  out  4  one-hot start pulse, bit i = encoder layer i+1
enc_done  in  4  done from encoder layer i+1
lambda_start  out  1  start pulse, lambda/reparam unit
lambda_done  in  1  done from lambda unit
act_start  out  1  start pulse, shared activation unit
act_done  in  1  done from activation unit
act_mode  out  1  0 = softplus, 1 = sigmoid
act_sel  out  2  source layer routed to activation unit (0..3 = ENC1..ENC4)
out_valid  out  1  run complete, result valid
out_ready  in  1  downstream accepts result
busy  out  1  run in progress (SETTLE/ISSUE/WAIT/HOLD)
timeout_err  out  1  sticky watchdog error
clr_err  in  1  clears error, returns to IDLE
stage_id  out  4  debug: current stage index 0..8, 15 when not sequencing
cycle_cnt  out  CNT_W  debug: cycles since acceptance, saturating

Behaviour:
- Reset (async, low): state=IDLE, stage=0, all start pulses 0, act_mode=0, act_sel=0, out_valid=0, timeout_err=0, busy=0, stage_id=15, cycle_cnt=0. in_ready=1 (IDLE).
- Starts deassert immediately on reset assertion mid-run. No partial state survives.
- Stage table, index k:
  - 0 ENC1 (enc_done[0])
  - 1 ACT sel0 mode0
  - 2 ENC2 (enc_done[1])
  - 3 ACT sel1 mode0
  - 4 LAMBDA
  - 5 ENC3 (enc_done[2])
  - 6 ACT sel2 mode0
  - 7 ENC4 (enc_done[3])
  - 8 ACT sel3 mode1
- States:
  - IDLE: in_ready=1. in_valid&in_ready -> SETTLE, cycle_cnt cleared, settle counter loaded with OFFSET.
  - SETTLE: exactly OFFSET cycles, then ISSUE with k=0.
  - ISSUE: one cycle; the start output for stage k is high this cycle only. act_mode/act_sel are updated this cycle for ACT stages. Watchdog is cleared. Next state is WAIT.
  - WAIT: samples only stage k's done.
    - Done high: k<8 -> k+1, ISSUE. k=8 -> HOLD.
    - Watchdog counts WAIT cycles. Done absent for TIMEOUT_CC cycles -> ERR.
    - Done and watchdog expiry in the same cycle: done wins.
  - HOLD: out_valid=1 until out_ready is sampled high, then IDLE. out_valid falls and in_ready rises in the same cycle.
  - ERR: timeout_err=1, all starts 0, busy=0, in_ready=0, stage_id holds the failing k. clr_err -> IDLE, timeout_err=0.
- Stray done signals are ignored: done from non-current units, and any done sampled during ISSUE. Units must assert done at least 1 cycle after start. A done held high across the next ISSUE is not re-used, because it is sampled only in WAIT of that stage.
- act_mode/act_sel hold their values between ACT stages and are never glitched.
- At most one start bit among enc_start/lambda_start/act_start is high in any cycle.
- Latency, acceptance at cycle c0, done returned on the first WAIT cycle:
  - Stage k ISSUE at c0+OFFSET+1+2k.
  - out_valid first high at c0+OFFSET+19 (c0+21 at default).
- cycle_cnt increments every cycle outside IDLE/ERR, saturates at 2^CNT_W-1, and holds its value in IDLE until the next acceptance.
- clr_err outside ERR has no effect. in_valid outside IDLE is ignored; it is not queued.

Test Plan:
- Ideal units (done 1 cycle after each start), OFFSET=2, accept at c0 -> start pulses at c0+3,5,...,19 in table order. out_valid at c0+21. act_mode=1 only for the pulse at c0+19, act_sel=0,1,2,3 at the ACT pulses.
- Variable latency: ENC1 done after 10 cycles, LAMBDA after 8, others after 3 -> order preserved, no overlapping starts, out_valid held 5 cycles until out_ready, then in_ready=1.
- Stray enc_done[3] pulsed during ENC1 WAIT, and act_done held high through ACT1->ENC2 -> neither advances early. ENC2 still waits for enc_done[1].
- Watchdog: TIMEOUT_CC=64, ENC3 done withheld -> ERR after 64 WAIT cycles, timeout_err=1, stage_id=5. Done on exactly the 64th WAIT cycle -> advances, no error. clr_err -> IDLE, in_ready=1.
- Reset asserted mid-LAMBDA WAIT -> all starts 0 and in_ready=1 immediately. After release, a new run completes with correct timing.
- Back-to-back: out_ready held 1 and in_valid held 1 -> second acceptance 1 cycle after the first out_valid. cycle_cnt restarts at 0.
